// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: state encoding and default timing constants for the PLL lock sequencer
package pll_seq_pkg;
  typedef enum logic [2:0] {S_RESET, S_WAIT_LOCK, S_QUALIFY, S_RELEASE, S_RUN, S_FAULT} state_t;
  localparam int RST_PULSE_CYC_DEF = 250;
  localparam int LOCK_TIMEOUT_CYC_DEF = 25000;
  localparam int LOCK_STABLE_CYC_DEF = 2500;
  localparam int SYS_RST_HOLD_CYC_DEF = 64;
  localparam int MAX_RETRIES_DEF = 7;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single bit, cleared by asynchronous reset
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s1_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, s1_q} <= 2'b00;
    else {q, s1_q} <= {s1_q, d};
endmodule

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: pulses PLL reset, qualifies lock, releases sys_rst, retries and faults
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYC = RST_PULSE_CYC_DEF,
  parameter int LOCK_TIMEOUT_CYC = LOCK_TIMEOUT_CYC_DEF,
  parameter int LOCK_STABLE_CYC = LOCK_STABLE_CYC_DEF,
  parameter int SYS_RST_HOLD_CYC = SYS_RST_HOLD_CYC_DEF,
  parameter int MAX_RETRIES = MAX_RETRIES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       clk_ready,
  output logic       fault,
  output logic [2:0] retry_count,
  output logic [7:0] loss_count
);
  state_t state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d, to_q, to_d, stb_q, stb_d;
  logic [2:0] retry_q, retry_d;
  logic [7:0] loss_q, loss_d;
  logic pll_rst_q, pll_rst_d, sys_rst_q, sys_rst_d, rdy_q, rdy_d, fault_q, fault_d;
  logic lk_s, timeout;
  sync_2ff u_lk_sync (.clk(refclk), .rst(rst), .d(pll_locked), .q(lk_s));
  // timeout counts from PLL reset release and is never cleared by a lock flap
  assign timeout = to_q == CNT_W'(LOCK_TIMEOUT_CYC - 1);
  always_comb begin
    state_d = state_q;
    tmr_d = tmr_q;
    to_d = to_q;
    stb_d = stb_q;
    retry_d = retry_q;
    loss_d = loss_q;
    if (force_relock) begin
      state_d = S_RESET;
      tmr_d = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RESET:
          if (tmr_q == CNT_W'(RST_PULSE_CYC - 1)) begin
            state_d = S_WAIT_LOCK;
            tmr_d = '0;
            to_d = '0;
          end else tmr_d = tmr_q + 1'b1;
        S_WAIT_LOCK, S_QUALIFY: begin
          to_d = to_q + 1'b1;
          if (timeout) begin
            tmr_d = '0;
            state_d = retry_q == 3'(MAX_RETRIES) ? S_FAULT : S_RESET;
            retry_d = retry_q == 3'(MAX_RETRIES) ? retry_q : retry_q + 3'd1;
          end else if (!lk_s) state_d = S_WAIT_LOCK;
          else if (state_q == S_WAIT_LOCK) begin
            state_d = S_QUALIFY;
            stb_d = '0;
          end else if (stb_q == CNT_W'(LOCK_STABLE_CYC - 1)) begin
            state_d = S_RELEASE;
            tmr_d = '0;
          end else stb_d = stb_q + 1'b1;
        end
        S_RELEASE, S_RUN:
          if (!lk_s) begin
            state_d = S_RESET;
            tmr_d = '0;
            loss_d = loss_q + {7'd0, loss_q != 8'hff};
          end else if (state_q == S_RELEASE) begin
            if (tmr_q == CNT_W'(SYS_RST_HOLD_CYC - 1)) begin
              state_d = S_RUN;
              retry_d = '0;
            end else tmr_d = tmr_q + 1'b1;
          end
        default: ;
      endcase
    end
    pll_rst_d = state_d == S_RESET || state_d == S_FAULT;
    sys_rst_d = state_d != S_RUN;
    rdy_d = state_d == S_RUN;
    fault_d = state_d == S_FAULT;
  end
  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      state_q <= S_RESET;
      tmr_q <= '0;
      to_q <= '0;
      stb_q <= '0;
      retry_q <= '0;
      loss_q <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      rdy_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q <= tmr_d;
      to_q <= to_d;
      stb_q <= stb_d;
      retry_q <= retry_d;
      loss_q <= loss_d;
      pll_rst_q <= pll_rst_d;
      sys_rst_q <= sys_rst_d;
      rdy_q <= rdy_d;
      fault_q <= fault_d;
    end
  assign pll_rst = pll_rst_q;
  assign sys_rst = sys_rst_q;
  assign clk_ready = rdy_q;
  assign fault = fault_q;
  assign retry_count = retry_q;
  assign loss_count = loss_q;
endmodule
